// File: rtl/drlp_img_loader_if.sv
// rtl/drlp_img_loader_if.sv - pixel stream and image-buffer write bus for the DRLP image loader
interface drlp_img_loader_if #(
   parameter int DATA_WIDTH       = 8,
   parameter int ADDR_WIDTH       = 10,
   parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * 6
);
   logic                        i_px_valid;
   logic [DATA_WIDTH-1:0]       i_px_data;
   logic                        o_px_ready;
   logic                        o_wr_en;
   logic [ADDR_WIDTH-1:0]       o_wr_addr;
   logic [TOTAL_DATA_WIDTH-1:0] o_wr_data;

   modport master (
      output i_px_valid, i_px_data,
      input  o_px_ready, o_wr_en, o_wr_addr, o_wr_data
   );

   modport slave (
      input  i_px_valid, i_px_data,
      output o_px_ready, o_wr_en, o_wr_addr, o_wr_data
   );
endinterface

// File: rtl/drlp_img_loader.sv
// rtl/drlp_img_loader.sv - packs six pixels per word and writes a run of words into the image buffer
module drlp_img_loader #(
   parameter int DATA_WIDTH       = 8,
   parameter int ADDR_WIDTH       = 10,
   parameter int TOTAL_DATA_WIDTH = DATA_WIDTH * 6
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ADDR_WIDTH-1:0] i_num_words,
   drlp_img_loader_if.slave      px_if,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int LANES = 6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FILL  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [ADDR_WIDTH-1:0]       base_q;
   logic [ADDR_WIDTH-1:0]       num_q;
   logic [ADDR_WIDTH-1:0]       word_cnt_q;
   logic [2:0]                  lane_q;
   logic [TOTAL_DATA_WIDTH-1:0] pack_q;

   logic px_accept;
   logic start_accept;
   logic last_lane;
   logic last_word;

   assign start_accept = (state_q == S_IDLE) && i_start;
   assign px_accept    = (state_q == S_FILL) && px_if.i_px_valid;
   assign last_lane    = (lane_q == 3'(LANES - 1));
   assign last_word    = (word_cnt_q == (num_q - ADDR_WIDTH'(1)));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = (i_num_words != '0) ? S_FILL : S_DONE;
            end
         end
         S_FILL: begin
            if (px_accept && last_lane) begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            state_d = last_word ? S_DONE : S_FILL;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Job parameters are latched once so upstream may change them while the job runs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         base_q     <= '0;
         num_q      <= '0;
         word_cnt_q <= '0;
      end else if (start_accept) begin
         base_q     <= i_base_addr;
         num_q      <= i_num_words;
         word_cnt_q <= '0;
      end else if ((state_q == S_WRITE) && !last_word) begin
         word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lane_q <= '0;
      end else if (start_accept) begin
         lane_q <= '0;
      end else if (px_accept) begin
         lane_q <= last_lane ? 3'd0 : lane_q + 3'd1;
      end
   end

   // Every lane is overwritten before each write, so the word needs no clearing between words.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pack_q <= '0;
      end else if (px_accept) begin
         for (int k = 0; k < LANES; k++) begin
            if (lane_q == 3'(k)) begin
               pack_q[k*DATA_WIDTH +: DATA_WIDTH] <= px_if.i_px_data;
            end
         end
      end
   end

   assign px_if.o_px_ready = (state_q == S_FILL);
   assign px_if.o_wr_en    = (state_q == S_WRITE);
   assign px_if.o_wr_addr  = base_q + word_cnt_q;
   assign px_if.o_wr_data  = pack_q;
   assign o_busy           = (state_q != S_IDLE);
   assign o_done           = (state_q == S_DONE);

endmodule

// File: tb/tb_drlp_img_loader.sv
// tb/tb_drlp_img_loader.sv - scoreboard bench for drlp_img_loader with randomized pixel streams
module tb_drlp_img_loader;
   localparam int DW = 8;
   localparam int AW = 10;
   localparam int TW = DW * 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base = '0;
   logic [AW-1:0] num = '0;
   logic          busy;
   logic          done;

   drlp_img_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_DATA_WIDTH(TW)) ifc ();

   drlp_img_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TOTAL_DATA_WIDTH(TW)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_base_addr (base),
      .i_num_words (num),
      .px_if       (ifc),
      .o_busy      (busy),
      .o_done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [TW-1:0] data;
      bit            last;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_done_cnt = 0;
   int  n_cmp = 0;
   int  n_err = 0;
   bit  full_rate = 0;
   int  cyc = 0;
   int  start_cyc = 0;
   int  start_num = 0;
   int  acc_cnt = 0;
   bit  want_wr = 0;
   bit  want_done = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: samples on the falling edge and pops the scoreboard on every write/done.
   always @(negedge clk) begin
      wr_t e;
      cyc++;
      if (!rst_n) begin
         acc_cnt   = 0;
         want_wr   = 0;
         want_done = 0;
      end else begin
         if (want_wr) check("wr_after_6th_px", ifc.o_wr_en, 1);
         want_wr = 0;
         if (want_done) check("done_timing", done, 1);
         want_done = 0;
         if (start && !busy) begin
            start_cyc = cyc;
            start_num = int'(num);
            if (num == '0) want_done = 1;
         end
         if (ifc.i_px_valid && ifc.o_px_ready) begin
            acc_cnt++;
            if (acc_cnt % 6 == 0) want_wr = 1;
         end
         if (ifc.o_wr_en) begin
            check("ready_low_in_write", ifc.o_px_ready, 0);
            check("write_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
               e = exp_wr.pop_front();
               check("wr_addr", ifc.o_wr_addr, e.addr);
               check("wr_data", ifc.o_wr_data, e.data);
               if (e.last) want_done = 1;
            end
         end
         if (done) begin
            check("busy_with_done", busy, 1);
            check("done_expected", exp_done_cnt != 0, 1);
            if (exp_done_cnt != 0) begin
               exp_done_cnt--;
               if (full_rate) check("job_cycles", cyc - start_cyc, 7 * start_num + 1);
            end
         end
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 50 && busy; i++) @(posedge clk);
      #1;
      check("idle_before_start", busy, 0);
   endtask

   task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] n);
      @(posedge clk);
      #1;
      start = 1'b1;
      base  = b;
      num   = n;
      @(posedge clk);
      #1;
      start = 1'b0;
      base  = AW'($urandom);
      num   = AW'($urandom);
   endtask

   // mode 1: valid always high, 2: valid toggles, other: random valid
   task automatic send_pixels(input logic [DW-1:0] px[$], input int mode, input int max_n);
      int   idx = 0;
      int   guard = 0;
      int   want;
      logic v;
      want = (px.size() < max_n) ? px.size() : max_n;
      while (idx < want && guard < 2000) begin
         case (mode)
            1:       v = 1'b1;
            2:       v = (guard % 2 == 0);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         ifc.i_px_valid = v;
         ifc.i_px_data  = v ? px[idx] : DW'($urandom);
         @(negedge clk);
         if (v && ifc.o_px_ready) idx++;
         @(posedge clk);
         #1;
         guard++;
      end
      ifc.i_px_valid = 1'b0;
      check("pixels_sent", idx, want);
   endtask

   task automatic wait_done_drained();
      for (int i = 0; i < 100 && exp_done_cnt != 0; i++) @(posedge clk);
      check("job_completed", exp_done_cnt, 0);
      check("writes_drained", exp_wr.size(), 0);
   endtask

   task automatic run_job(input logic [AW-1:0] b, input int n, input int mode, input bit inc, input bit glitch);
      logic [DW-1:0] px[$];
      logic [DW-1:0] p;
      wr_t           e;
      wait_idle();
      for (int w = 0; w < n; w++) begin
         e.data = '0;
         for (int k = 0; k < 6; k++) begin
            p = inc ? DW'(px.size() + 1) : DW'($urandom);
            px.push_back(p);
            e.data = e.data | (TW'(p) << (DW * k));
         end
         e.addr = AW'(int'(b) + w);
         e.last = (w == n - 1);
         exp_wr.push_back(e);
      end
      exp_done_cnt++;
      full_rate = (mode == 1);
      start_job(b, AW'(n));
      if (glitch) begin
         fork
            send_pixels(px, mode, 1 << 30);
            begin
               repeat (3) @(posedge clk);
               #2;
               start = 1'b1;
               base  = b + AW'(5);
               @(posedge clk);
               #2;
               start = 1'b0;
            end
         join
      end else begin
         send_pixels(px, mode, 1 << 30);
      end
      wait_done_drained();
   endtask

   initial begin
      logic [DW-1:0] px[$];
      ifc.i_px_valid = 1'b0;
      ifc.i_px_data  = '0;
      #2 rst_n = 1'b0;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", ifc.o_px_ready, 0);
      check("rst_wr_en", ifc.o_wr_en, 0);
      check("rst_wr_addr", ifc.o_wr_addr, 0);
      check("rst_wr_data", ifc.o_wr_data, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      run_job(10'h010, 2, 1, 1, 0);
      run_job(10'h3FF, 2, 1, 0, 0);

      wait_idle();
      exp_done_cnt++;
      full_rate = 1;
      start_job(10'h055, 10'd0);
      check("num0_busy_first", busy, 1);
      check("num0_done_first", done, 1);
      @(posedge clk);
      #1;
      check("num0_busy_after", busy, 0);
      wait_done_drained();

      run_job(AW'($urandom), 1, 2, 0, 0);

      // Abandon a job after three pixels; nothing may be written or signalled.
      wait_idle();
      full_rate = 0;
      for (int i = 0; i < 6; i++) px.push_back(DW'($urandom));
      start_job(10'h123, 10'd1);
      send_pixels(px, 1, 3);
      #3 rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_ready", ifc.o_px_ready, 0);
      check("abort_wr_en", ifc.o_wr_en, 0);
      check("abort_wr_addr", ifc.o_wr_addr, 0);
      check("abort_wr_data", ifc.o_wr_data, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      run_job(10'h200, 1, 1, 1, 0);

      run_job(10'h0A0, 2, 3, 0, 1);

      for (int j = 0; j < 8; j++) begin
         run_job(AW'($urandom), $urandom_range(0, 4), $urandom_range(1, 3), 0, 0);
      end

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/drlp_img_loader.md
DRLP_IMG_LOADER -- requirements
Module: drlp_img_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one input pixel.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: image-buffer word address width.
REQ-003 SHALL have parameter TOTAL_DATA_WIDTH, default DATA_WIDTH*6: packed word width, six pixels per word.
REQ-004 SHALL have port i_clk  input  1: single clock; all state on rising edge.
REQ-005 SHALL have port i_rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port i_start  input  1: start one load job; sampled only in IDLE.
REQ-007 SHALL have port i_base_addr  input  ADDR_WIDTH: first word address, captured on accepted start.
REQ-008 SHALL have port i_num_words  input  ADDR_WIDTH: number of words to write, captured on accepted start.
REQ-009 SHALL have port i_px_valid  input  1: upstream pixel valid.
REQ-010 SHALL have port i_px_data  input  DATA_WIDTH: upstream pixel.
REQ-011 SHALL have port o_px_ready  output  1: loader accepts a pixel this cycle.
REQ-012 SHALL have port o_wr_en  output  1: image-buffer write strobe.
REQ-013 SHALL have port o_wr_addr  output  ADDR_WIDTH: image-buffer write address.
REQ-014 SHALL have port o_wr_data  output  TOTAL_DATA_WIDTH: packed write word.
REQ-015 SHALL have port o_busy  output  1: high in any state other than IDLE.
REQ-016 SHALL have port o_done  output  1: one-cycle pulse at job completion.

Function
REQ-017 SHALL implement FSM states IDLE, FILL, WRITE, DONE.
REQ-018 IDLE: i_start=1 SHALL capture base/count, clear lane and word counters; next state FILL if i_num_words!=0, else DONE.
REQ-019 A pixel SHALL be accepted only on a cycle with i_px_valid=1 and o_px_ready=1; o_px_ready SHALL be 1 only in FILL.
REQ-020 Lane counter (0..5) SHALL place accepted pixel k at o_wr_data bits [k*DATA_WIDTH +: DATA_WIDTH]; first pixel in the least-significant lane.
REQ-021 Acceptance of lane 5 SHALL move FILL->WRITE and reset the lane counter to 0.
REQ-022 WRITE SHALL last exactly one cycle with o_wr_en=1, o_wr_addr=(base+word_cnt) mod 2^ADDR_WIDTH, o_wr_data=packed word; write strobe occurs the cycle after the 6th pixel is accepted.
REQ-023 WRITE exit: if word_cnt==num_words-1 go to DONE, else increment word_cnt and go to FILL.
REQ-024 DONE SHALL last one cycle with o_done=1, then return to IDLE; o_done SHALL be 0 in all other states.
REQ-025 o_wr_en SHALL be 0 outside WRITE; o_wr_addr/o_wr_data are don't-care when o_wr_en=0.
REQ-026 i_start in FILL/WRITE/DONE SHALL be ignored; no queuing.
REQ-027 Address wrap: base+word_cnt past 2^ADDR_WIDTH-1 SHALL wrap to 0 without error.
REQ-028 i_px_valid deasserting mid-word SHALL stall the loader in FILL with lane contents and lane counter held.
REQ-029 Sustained throughput with i_px_valid held high SHALL be 6 pixels per 7 cycles.
REQ-030 i_base_addr/i_num_words changes after start SHALL have no effect on the running job.

Reset
REQ-031 i_rst_n=0 SHALL immediately force IDLE, o_px_ready=0, o_wr_en=0, o_busy=0, o_done=0, o_wr_addr=0, o_wr_data=0, counters=0.
REQ-032 Reset mid-job SHALL abandon the job: partially packed word discarded, no write issued, no o_done pulse.
REQ-033 After reset release, the first accepted i_start SHALL begin a fresh job with lane 0.

Verification
REQ-034 Start base=0x010, num=2; stream bytes 0x01..0x0C with valid high -> writes addr 0x010 data 0x060504030201, addr 0x011 data 0x0C0B0A090807; o_done one cycle after the second write.
REQ-035 Start base=0x3FF, num=2 -> write addresses 0x3FF then 0x000.
REQ-036 Start num=0 -> no o_wr_en; o_done pulses the cycle after start; o_busy high for exactly that one cycle.
REQ-037 Start num=1, valid toggled 1/0 every cycle -> single write after 6 accepted pixels, data packed in order; o_px_ready=0 during WRITE.
REQ-038 Assert i_rst_n=0 after 3 pixels of a num=1 job -> outputs cleared asynchronously; no write; no o_done; a new job then packs from lane 0.
REQ-039 Pulse i_start with new base during FILL -> ignored; writes use the original base.
